// File: rtl/layer_act_loader.sv
// Serial-to-parallel activation loader: collects NUM_IN streamed words into a fill bank,
// then swaps them onto a held-stable parallel bus with a latency-aligned result strobe.
module layer_act_loader #(
    parameter int NUM_IN   = 15,
    parameter int DATA_W   = 32,
    parameter int NODE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [NUM_IN*DATA_W-1:0]   a_bus,
    output logic                       a_valid,
    output logic                       res_valid,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int HC_W  = (NODE_LAT > 1) ? $clog2(NODE_LAT) : 1;

    typedef enum logic {FILL, FULL} fill_t;
    typedef enum logic [1:0] {IDLE, HOLD, READY} pres_t;

    fill_t fill_state, fill_next;
    pres_t pres_state, pres_next;

    logic [IDX_W-1:0] wr_idx, wr_idx_next;
    logic [HC_W-1:0]  hold_cnt, hold_next;
    logic             err_next, rv_next, load;
    logic             accept, at_end, swap;

    logic [NUM_IN-1:0][DATA_W-1:0] fill_bank;
    logic [NUM_IN-1:0][DATA_W-1:0] present_bank;

    // The present bank is the output register itself, so a_bus changes only on a swap.
    assign a_bus  = present_bank;
    assign accept = s_valid && s_ready;
    assign at_end = (wr_idx == IDX_W'(NUM_IN - 1));
    assign swap   = (fill_state == FULL) && (pres_state == IDLE || pres_state == READY);

    always_comb begin
        fill_next   = fill_state;
        wr_idx_next = wr_idx;
        err_next    = 1'b0;
        case (fill_state)
            FILL: begin
                if (accept) begin
                    if (at_end) begin
                        wr_idx_next = '0;
                        if (s_last) fill_next = FULL;
                        else        err_next  = 1'b1;
                    end else if (s_last) begin
                        wr_idx_next = '0;
                        err_next    = 1'b1;
                    end else begin
                        wr_idx_next = wr_idx + 1'b1;
                    end
                end
            end
            FULL: if (swap) fill_next = FILL;
            default: fill_next = FILL;
        endcase
    end

    always_comb begin
        pres_next = pres_state;
        hold_next = hold_cnt;
        rv_next   = 1'b0;
        load      = 1'b0;
        case (pres_state)
            IDLE, READY: begin
                if (swap) begin
                    load      = 1'b1;
                    hold_next = '0;
                    pres_next = HOLD;
                end
            end
            HOLD: begin
                // Strobe lands NODE_LAT edges after the swap edge.
                if (hold_cnt == HC_W'(NODE_LAT - 1)) begin
                    rv_next   = 1'b1;
                    pres_next = READY;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            default: pres_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_state   <= FILL;
            pres_state   <= IDLE;
            wr_idx       <= '0;
            hold_cnt     <= '0;
            s_ready      <= 1'b0;
            a_valid      <= 1'b0;
            res_valid    <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
            fill_bank    <= '0;
            present_bank <= '0;
        end else begin
            fill_state <= fill_next;
            pres_state <= pres_next;
            wr_idx     <= wr_idx_next;
            hold_cnt   <= hold_next;
            // Registered from next state so it never depends on s_valid combinationally.
            s_ready    <= (fill_next == FILL);
            res_valid  <= rv_next;
            frame_err  <= err_next;
            if (accept && fill_state == FILL)
                fill_bank[wr_idx] <= s_data;
            if (load) begin
                present_bank <= fill_bank;
                frame_cnt    <= frame_cnt + 16'd1;
                a_valid      <= 1'b1;
            end
        end
    end

endmodule
